// File: rtl/gate_full_adder_pkg.sv
// gate_full_adder_pkg
// Shared definitions for the gate-level reference adder.
//   DEFAULT_WIDTH : default operand width of gate_full_adder (classic 1-bit full adder)
//   REF_MAX_WIDTH : widest operand the golden model ref_add accepts
//   ref_add()     : behavioural golden result {cout, sum} = a + b + cin, meant for
//                   checking benches only; the adder datapath never uses it.
package gate_full_adder_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int REF_MAX_WIDTH = 32;

  // Operands narrower than REF_MAX_WIDTH are zero-extended by the caller; the
  // carry-out of a narrow adder then lands in bit WIDTH of the returned value.
  function automatic logic [REF_MAX_WIDTH:0] ref_add(
    input logic [REF_MAX_WIDTH-1:0] a,
    input logic [REF_MAX_WIDTH-1:0] b,
    input logic                     cin
  );
    return {1'b0, a} + {1'b0, b} + {{REF_MAX_WIDTH{1'b0}}, cin};
  endfunction

endpackage

// File: rtl/gate_fa_cell.sv
// gate_fa_cell
// One-bit full adder built from primitive gates only (2 xor, 2 and, 1 or).
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   sum   : a ^ b ^ cin
//   cout  : (a & b) | (cin & (a ^ b))
// X/Z on any input propagates according to the primitive gate tables.
module gate_fa_cell
  import gate_full_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic prop;
  logic gen;
  logic prop_carry;

  // The propagate term is shared between the sum and the carry path.
  xor u_xor_prop (prop, a, b);
  xor u_xor_sum  (sum, prop, cin);
  and u_and_gen  (gen, a, b);
  and u_and_prop (prop_carry, cin, prop);
  or  u_or_cout  (cout, gen, prop_carry);

endmodule

// File: rtl/gate_full_adder.sv
// gate_full_adder
// Ripple-carry adder of WIDTH gate-level full-adder cells with an optional
// registered copy of the result.
// Parameters:
//   WIDTH  : operand width in bits (>= 1), one gate_fa_cell per bit
// Ports:
//   clk    : rising edge samples sum/cout into sum_q/cout_q
//   rst_n  : asynchronous active-low reset, clears sum_q/cout_q only
//   a, b   : WIDTH-bit operands
//   cin    : carry into bit 0
//   sum    : combinational sum, independent of clk/rst_n
//   cout   : combinational carry out of the MSB cell
//   sum_q  : sum registered on clk (1 cycle latency)
//   cout_q : cout registered on clk
module gate_full_adder
  import gate_full_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q
);

  // carry[i] is the carry into cell i; carry[WIDTH] leaves the MSB cell.
  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  // Cells are chained purely structurally so the adder path stays gate-level.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    gate_fa_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];

  // Output register stage; reset only touches these flops, never the
  // combinational result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum;
      cout_q <= cout;
    end
  end

endmodule

// File: tb/tb_gate_full_adder.sv
// tb_gate_full_adder
// Directed bench for gate_full_adder: a 1-bit instance (combinational and
// registered paths), a 4-bit instance (ripple carry) and a 1-bit instance whose
// clk/rst_n are tied off to show the combinational path needs neither.
module tb_gate_full_adder;
  import gate_full_adder_pkg::*;

  logic       clk;
  logic       rst_n;

  logic       a1, b1, cin1;
  logic       sum1, cout1, sum1_q, cout1_q;

  logic [3:0] a4, b4;
  logic       cin4;
  logic [3:0] sum4, sum4_q;
  logic       cout4, cout4_q;

  logic       an, bn, cinn;
  logic       sumn, coutn, sumn_q, coutn_q;

  int checks;
  int failures;

  gate_full_adder #(.WIDTH(1)) u_dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a1),
    .b      (b1),
    .cin    (cin1),
    .sum    (sum1),
    .cout   (cout1),
    .sum_q  (sum1_q),
    .cout_q (cout1_q)
  );

  gate_full_adder #(.WIDTH(4)) u_dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a4),
    .b      (b4),
    .cin    (cin4),
    .sum    (sum4),
    .cout   (cout4),
    .sum_q  (sum4_q),
    .cout_q (cout4_q)
  );

  gate_full_adder #(.WIDTH(1)) u_dutn (
    .clk    (1'b0),
    .rst_n  (1'b0),
    .a      (an),
    .b      (bn),
    .cin    (cinn),
    .sum    (sumn),
    .cout   (coutn),
    .sum_q  (sumn_q),
    .cout_q (coutn_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic ia, input logic ib, input logic ic);
    a1   = ia;
    b1   = ib;
    cin1 = ic;
  endtask

  task automatic applyWide(input logic [3:0] ia, input logic [3:0] ib, input logic ic);
    a4   = ia;
    b4   = ib;
    cin4 = ic;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hand-computed full-adder truth table, index = {a, b, cin}.
  logic exp_s [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic exp_c [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    logic [2:0]  v;
    logic [32:0] ref_val;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyWide(4'h0, 4'h0, 1'b0);
    an = 1'b0; bn = 1'b0; cinn = 1'b0;
    #1;
    checkOutput("reset_sum_q",   8'(sum1_q),  8'h00);
    checkOutput("reset_cout_q",  8'(cout1_q), 8'h00);
    checkOutput("reset_sum4_q",  8'(sum4_q),  8'h00);
    checkOutput("reset_cout4_q", 8'(cout4_q), 8'h00);

    // Exhaustive truth table while reset is held across clock edges.
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      applyStimulus(v[2], v[1], v[0]);
      #1;
      checkOutput($sformatf("tt_sum_%0d", i),  8'(sum1),  8'(exp_s[i]));
      checkOutput($sformatf("tt_cout_%0d", i), 8'(cout1), 8'(exp_c[i]));
      @(posedge clk); #1;
      checkOutput($sformatf("held_sum_q_%0d", i),  8'(sum1_q),  8'h00);
      checkOutput($sformatf("held_cout_q_%0d", i), 8'(cout1_q), 8'h00);
    end

    // Registered path after release: 1 + 1 + 0 loads on the next edge.
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    #1;
    checkOutput("pre_edge_sum_q",  8'(sum1_q),  8'h00);
    checkOutput("pre_edge_cout_q", 8'(cout1_q), 8'h00);
    @(posedge clk); #1;
    checkOutput("reg_sum_q_110",  8'(sum1_q),  8'h00);
    checkOutput("reg_cout_q_110", 8'(cout1_q), 8'h01);

    applyStimulus(1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("hold_cout_q_100", 8'(cout1_q), 8'h01);
    @(posedge clk); #1;
    checkOutput("reg_sum_q_100",  8'(sum1_q),  8'h01);
    checkOutput("reg_cout_q_100", 8'(cout1_q), 8'h00);

    // Asynchronous reset between edges with sum_q = 1.
    rst_n = 1'b0;
    #1;
    checkOutput("async_sum_q",  8'(sum1_q),  8'h00);
    checkOutput("async_cout_q", 8'(cout1_q), 8'h00);
    checkOutput("async_comb_sum", 8'(sum1), 8'h01);
    applyStimulus(1'b1, 1'b1, 1'b1);
    #1;
    checkOutput("rst_comb_sum",  8'(sum1),  8'h01);
    checkOutput("rst_comb_cout", 8'(cout1), 8'h01);
    rst_n = 1'b1;
    #1;
    checkOutput("release_pre_edge_sum_q", 8'(sum1_q), 8'h00);
    @(posedge clk); #1;
    checkOutput("reload_sum_q",  8'(sum1_q),  8'h01);
    checkOutput("reload_cout_q", 8'(cout1_q), 8'h01);

    // Four-bit ripple vectors.
    applyWide(4'hF, 4'h0, 1'b1);
    #1;
    checkOutput("w4_f_0_1_sum",  8'(sum4),  8'h00);
    checkOutput("w4_f_0_1_cout", 8'(cout4), 8'h01);
    applyWide(4'h7, 4'h8, 1'b0);
    #1;
    checkOutput("w4_7_8_0_sum",  8'(sum4),  8'h0F);
    checkOutput("w4_7_8_0_cout", 8'(cout4), 8'h00);
    applyWide(4'h5, 4'hA, 1'b1);
    #1;
    checkOutput("w4_5_a_1_sum",  8'(sum4),  8'h00);
    checkOutput("w4_5_a_1_cout", 8'(cout4), 8'h01);
    applyWide(4'h3, 4'h4, 1'b0);
    #1;
    checkOutput("w4_3_4_0_sum",  8'(sum4),  8'h07);
    checkOutput("w4_3_4_0_cout", 8'(cout4), 8'h00);
    applyWide(4'h9, 4'h9, 1'b1);
    #1;
    checkOutput("w4_9_9_1_sum",  8'(sum4),  8'h03);
    checkOutput("w4_9_9_1_cout", 8'(cout4), 8'h01);
    @(posedge clk); #1;
    checkOutput("w4_reg_sum_q",  8'(sum4_q),  8'h03);
    checkOutput("w4_reg_cout_q", 8'(cout4_q), 8'h01);

    // Tied-off clock/reset instance: combinational path only.
    for (int i = 0; i < 10; i++) begin
      v = 3'($urandom_range(0, 7));
      an = v[2]; bn = v[1]; cinn = v[0];
      #1;
      ref_val = ref_add({31'b0, v[2]}, {31'b0, v[1]}, v[0]);
      checkOutput($sformatf("nc_sum_%0d", i),  8'(sumn),  8'(ref_val[0]));
      checkOutput($sformatf("nc_cout_%0d", i), 8'(coutn), 8'(ref_val[1]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
